// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder control path and its datapath blocks.
package viterbi_pkg;
  localparam int FRAME_LEN  = 20;
  localparam int IDX_W      = 5;
  localparam int TB_TIMEOUT = 64;
  localparam int NUM_ST     = 256;
  localparam int ST_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_ACS  = 3'd2,
    ST_SEL  = 3'd3,
    ST_TB   = 3'd4,
    ST_OUT  = 3'd5
  } state_t;
endpackage

// File: rtl/viterbi_ctrl_if.sv
// Symbol-input and decoded-frame-output handshakes of the Viterbi controller.
interface viterbi_ctrl_if;
  // A beat transfers on a rising edge where valid and ready are both high.
  // o_out_valid is held until accepted; the symbol source may insert bubbles
  // by lowering i_sym_valid, and o_sym_ready never depends on i_sym_valid.
  logic i_sym_valid;
  logic o_sym_ready;
  logic o_out_valid;
  logic i_out_ready;

  modport slave  (input  i_sym_valid, i_out_ready, output o_sym_ready, o_out_valid);
  modport master (output i_sym_valid, i_out_ready, input  o_sym_ready, o_out_valid);
endinterface

// File: rtl/viterbi_step_cnt.sv
// Loadable single-direction index counter with a terminal-count flag.
module viterbi_step_cnt
  import viterbi_pkg::*;
#(
  parameter int W    = IDX_W,
  parameter int LAST = FRAME_LEN - 1,
  parameter bit UP   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; saturation is left to the caller via tc_o.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = UP ? cnt_q + W'(1) : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = UP ? (cnt_q == W'(LAST)) : (cnt_q == '0);
endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the Viterbi decoder: clear, ACS steps, min-node select,
// traceback, then hand the decoded frame downstream.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN  = viterbi_pkg::FRAME_LEN,
  parameter int IDX_W      = viterbi_pkg::IDX_W,
  parameter int TB_TIMEOUT = viterbi_pkg::TB_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  viterbi_ctrl_if.slave    hs,
  output logic             o_clr_metric,
  output logic             o_en_acs,
  output logic [IDX_W-1:0] o_step_idx,
  output logic             o_en_sel,
  input  logic             i_sel_done,
  output logic             o_en_t,
  output logic [IDX_W-1:0] o_tb_idx,
  input  logic             i_tb_done,
  output logic             o_busy,
  output logic             o_err,
  output state_t           o_dbg_state
);
  localparam int TO_W = $clog2(TB_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q;
  logic            clr_metric_q, en_sel_q, en_t_q, out_valid_q, busy_q, err_q;
  logic            sym_ready, accept, abort_act, sel_to_tb, timeout;
  logic            step_tc, tb_tc;

  assign sym_ready = (state_q == ST_ACS);
  assign accept    = hs.i_sym_valid & sym_ready;
  assign abort_act = i_abort & (state_q != ST_IDLE);
  assign sel_to_tb = (state_q == ST_SEL) & i_sel_done & ~i_abort;
  assign timeout   = (state_q == ST_TB) & ~i_tb_done & (to_q == TO_W'(TB_TIMEOUT - 1));

  viterbi_step_cnt #(.W(IDX_W), .LAST(FRAME_LEN - 1), .UP(1'b1)) u_step_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     ((state_q == ST_INIT) | abort_act),
    .load_val_i ('0),
    .en_i       (accept & ~step_tc),
    .cnt_o      (o_step_idx),
    .tc_o       (step_tc)
  );

  viterbi_step_cnt #(.W(IDX_W), .LAST(FRAME_LEN - 1), .UP(1'b0)) u_tb_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sel_to_tb | abort_act),
    .load_val_i (abort_act ? '0 : LAST_IDX),
    .en_i       ((state_q == ST_TB) & ~tb_tc),
    .cnt_o      (o_tb_idx),
    .tc_o       (tb_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_INIT;
      ST_INIT: state_d = ST_ACS;
      ST_ACS:  if (accept && step_tc) state_d = ST_SEL;
      ST_SEL:  if (i_sel_done) state_d = ST_TB;
      ST_TB: begin
        if (i_tb_done)    state_d = ST_OUT;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_OUT:  if (hs.i_out_ready) state_d = i_start ? ST_INIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort outranks every other transition.
    if (abort_act) state_d = ST_IDLE;
  end

  // Registered strobes are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      to_q         <= '0;
      clr_metric_q <= 1'b0;
      en_sel_q     <= 1'b0;
      en_t_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_q         <= (state_q == ST_TB && state_d == ST_TB) ? to_q + TO_W'(1) : '0;
      clr_metric_q <= (state_d == ST_INIT);
      en_sel_q     <= (state_d == ST_SEL);
      en_t_q       <= (state_d == ST_TB);
      out_valid_q  <= (state_d == ST_OUT);
      busy_q       <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && i_start) begin
        err_q <= 1'b0;
      end else if (timeout && !i_abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign hs.o_sym_ready = sym_ready;
  assign hs.o_out_valid = out_valid_q;
  assign o_en_acs       = accept;
  assign o_clr_metric   = clr_metric_q;
  assign o_en_sel       = en_sel_q;
  assign o_en_t         = en_t_q;
  assign o_busy         = busy_q;
  assign o_err          = err_q;
  assign o_dbg_state    = state_q;
endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl: randomized frames against a phase-level model.
module tb_viterbi_ctrl;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, sel_done = 1'b0, tb_done = 1'b0;
  logic clr_metric, en_acs, en_sel, en_t, busy, err;
  logic [IDX_W-1:0] step_idx, tb_idx;
  state_t dbg_state;

  viterbi_ctrl_if hs_if ();

  viterbi_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_abort      (abort),
    .hs           (hs_if),
    .o_clr_metric (clr_metric),
    .o_en_acs     (en_acs),
    .o_step_idx   (step_idx),
    .o_en_sel     (en_sel),
    .i_sel_done   (sel_done),
    .o_en_t       (en_t),
    .o_tb_idx     (tb_idx),
    .i_tb_done    (tb_done),
    .o_busy       (busy),
    .o_err        (err),
    .o_dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_vec = 0;
  int n_bad = 0;
  logic [IDX_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output vector for a given phase, from the state-level rules.
  task automatic chk_outs(input string ph, input state_t st, input logic clr,
                          input logic sel, input logic t, input logic ov);
    check({ph, "/state"},     32'(dbg_state),         32'(st));
    check({ph, "/clr"},       32'(clr_metric),        32'(clr));
    check({ph, "/en_sel"},    32'(en_sel),            32'(sel));
    check({ph, "/en_t"},      32'(en_t),              32'(t));
    check({ph, "/out_valid"}, 32'(hs_if.o_out_valid), 32'(ov));
    check({ph, "/busy"},      32'(busy),              32'(st != ST_IDLE));
    check({ph, "/sym_ready"}, 32'(hs_if.o_sym_ready), 32'(st == ST_ACS));
    check({ph, "/en_acs"},    32'(en_acs),            32'((st == ST_ACS) && hs_if.i_sym_valid));
  endtask

  // Driver: one full frame. chain requests a back-to-back start at the output handshake.
  task automatic run_frame(input bit skip_start, input int bubble_pct, input int sel_cyc,
                           input int tb_cyc, input int wait_cyc, input bit chain, input bit abort_out);
    int budget;
    if (!skip_start) begin
      start = 1'b1;
      tick();
    end
    start = 1'($urandom_range(1));
    hs_if.i_sym_valid = 1'($urandom_range(1));
    @(negedge clk);
    chk_outs("init", ST_INIT, 1'b1, 1'b0, 1'b0, 1'b0);
    check("init/err", 32'(err), 32'(0));
    tick();

    exp_q.delete();
    for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(IDX_W'(i));
    budget = 0;
    while (exp_q.size() > 0 && budget < 400) begin
      hs_if.i_sym_valid = ($urandom_range(99) >= bubble_pct);
      start = 1'($urandom_range(1));
      @(negedge clk);
      chk_outs("acs", ST_ACS, 1'b0, 1'b0, 1'b0, 1'b0);
      if (hs_if.i_sym_valid) check("acs/step_idx", 32'(step_idx), 32'(exp_q.pop_front()));
      tick();
      budget++;
    end
    check("acs/remaining", 32'(exp_q.size()), 32'(0));

    for (int s = 0; s < sel_cyc; s++) begin
      sel_done = (s == sel_cyc - 1);
      tb_done = 1'($urandom_range(1));
      hs_if.i_sym_valid = 1'($urandom_range(1));
      start = 1'($urandom_range(1));
      @(negedge clk);
      chk_outs("sel", ST_SEL, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    sel_done = 1'b0;

    for (int k = 0; k < tb_cyc; k++) begin
      tb_done = (k == tb_cyc - 1);
      sel_done = 1'($urandom_range(1));
      hs_if.i_sym_valid = 1'($urandom_range(1));
      start = 1'($urandom_range(1));
      @(negedge clk);
      chk_outs("tb", ST_TB, 1'b0, 1'b0, 1'b1, 1'b0);
      check("tb/tb_idx", 32'(tb_idx), (k < FRAME_LEN) ? 32'(FRAME_LEN - 1 - k) : 32'(0));
      tick();
    end
    tb_done = 1'b0;
    sel_done = 1'b0;

    for (int w = 0; w <= wait_cyc; w++) begin
      hs_if.i_out_ready = (w == wait_cyc);
      start = (w == wait_cyc) ? chain : 1'($urandom_range(1));
      abort = (w == wait_cyc) ? abort_out : 1'b0;
      hs_if.i_sym_valid = 1'($urandom_range(1));
      @(negedge clk);
      chk_outs("out", ST_OUT, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    hs_if.i_out_ready = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    hs_if.i_sym_valid = 1'b0;
    if (!(chain && !abort_out)) begin
      @(negedge clk);
      chk_outs("done", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Driver: start a frame and feed n valid symbols with no bubbles.
  task automatic start_and_feed(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    hs_if.i_sym_valid = 1'b1;
    repeat (n) tick();
    hs_if.i_sym_valid = 1'b0;
  endtask

  initial begin
    hs_if.i_sym_valid = 1'b0;
    hs_if.i_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_outs("por", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("por/err", 32'(err), 32'(0));
    check("por/step_idx", 32'(step_idx), 32'(0));

    // Reset in the middle of ACS.
    start_and_feed(7);
    @(negedge clk);
    check("pre_rst/step_idx", 32'(step_idx), 32'(7));
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_outs("mid_rst", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_rst/step_idx", 32'(step_idx), 32'(0));
    check("mid_rst/tb_idx", 32'(tb_idx), 32'(0));
    check("mid_rst/err", 32'(err), 32'(0));

    // Clean frames: exact traceback length, then an overlong one to see the index hold.
    run_frame(1'b0, 0, 3, FRAME_LEN, 0, 1'b0, 1'b0);
    run_frame(1'b0, 0, 1, FRAME_LEN + 4, 0, 1'b0, 1'b0);

    // Bubbles on the symbol input.
    for (int f = 0; f < 3; f++)
      run_frame(1'b0, 30, $urandom_range(1, 5), $urandom_range(1, 30), $urandom_range(0, 3), 1'b0, 1'b0);

    // Stalled output, then a back-to-back frame.
    run_frame(1'b0, 0, 2, 5, 10, 1'b1, 1'b0);
    run_frame(1'b1, 20, 2, 22, 0, 1'b0, 1'b0);

    // Abort coinciding with the output handshake and a restart request.
    run_frame(1'b0, 0, 1, 3, 2, 1'b1, 1'b1);

    // Traceback timeout.
    start_and_feed(FRAME_LEN);
    sel_done = 1'b1;
    tick();
    sel_done = 1'b0;
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      @(negedge clk);
      chk_outs("to_tb", ST_TB, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    @(negedge clk);
    chk_outs("to_idle", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_idle/err", 32'(err), 32'(1));
    for (int i = 0; i < 5; i++) begin
      hs_if.i_sym_valid = 1'($urandom_range(1));
      tb_done = 1'($urandom_range(1));
      tick();
      @(negedge clk);
      check("to_sticky/err", 32'(err), 32'(1));
    end
    hs_if.i_sym_valid = 1'b0;
    tb_done = 1'b0;
    run_frame(1'b0, 10, 2, 8, 1, 1'b0, 1'b0);

    // Abort at ACS step 5.
    start_and_feed(5);
    hs_if.i_sym_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk_outs("abort_acs", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_acs/step_idx", 32'(step_idx), 32'(0));
    hs_if.i_sym_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk_outs("abort_acs_idle", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Abort in SEL together with i_sel_done.
    start_and_feed(FRAME_LEN);
    @(negedge clk);
    chk_outs("sel_pre", ST_SEL, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    abort = 1'b1;
    sel_done = 1'b1;
    tick();
    abort = 1'b0;
    sel_done = 1'b0;
    @(negedge clk);
    chk_outs("abort_sel", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_sel/tb_idx", 32'(tb_idx), 32'(0));
    check("abort_sel/err", 32'(err), 32'(0));

    // Random frames.
    for (int f = 0; f < 4; f++)
      run_frame(1'b0, $urandom_range(0, 50), $urandom_range(1, 4), $urandom_range(1, 40),
                $urandom_range(0, 5), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/viterbi_ctrl.md
Name: viterbi_ctrl

Overview:
- Top-level sequencer for the Viterbi decoder datapath.
- Runs one frame at a time through four phases: path-metric clear, ACS/survivor write (one trellis step per accepted symbol), minimum-metric node selection, and traceback.
- Presents the decoded frame to downstream logic through a valid/ready handshake.
- Sits between the symbol source, the ACS/survivor-memory unit, the min-metric selector and the traceback/output unit.

Parameters:
- FRAME_LEN, 20: trellis steps (decoded bits) per frame; must match the traceback output width.
- IDX_W, 5: width of step/traceback index; ceil(log2(FRAME_LEN)).
- TB_TIMEOUT, 64: maximum cycles in TB waiting for i_tb_done before error abort.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- i_start  in  1  Request to decode a new frame; sampled only in IDLE.
- i_abort  in  1  Abandon the current frame.
- i_sym_valid  in  1  Input symbol pair valid.
- o_sym_ready  out  1  Controller accepts a symbol this cycle.
- o_clr_metric  out  1  One-cycle pulse that clears all path metrics.
- o_en_acs  out  1  ACS step enable and survivor-memory write strobe.
- o_step_idx  out  IDX_W  Survivor-memory write address for the current step.
- o_en_sel  out  1  Min-metric node search enable.
- i_sel_done  in  1  Selector has registered the winning node (i_sel_node is valid to traceback).
- o_en_t  out  1  Traceback enable.
- o_tb_idx  out  IDX_W  Survivor-memory read address during traceback.
- i_tb_done  in  1  Traceback unit has its o_data word complete.
- o_out_valid  out  1  Decoded frame available downstream.
- i_out_ready  in  1  Downstream accepts the frame.
- o_busy  out  1  High in every state except IDLE.
- o_err  out  1  Sticky traceback-timeout flag.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including o_err; step and traceback counters go to 0.
- Rule that applies to every output: all outputs are registered except o_sym_ready and o_en_acs, which are combinational from state and i_sym_valid.
- States: IDLE, INIT, ACS, SEL, TB, OUT.
- IDLE:
  - i_start=1 moves to INIT on the next edge.
  - o_err clears on that same edge.
- INIT (exactly 1 cycle):
  - o_clr_metric=1 and step counter cleared.
  - Next state is ACS.
- ACS:
  - o_sym_ready=1.
  - Accept condition is i_sym_valid & o_sym_ready. On accept, o_en_acs=1 in the same cycle, o_step_idx = current step, and step increments.
  - Accepting step FRAME_LEN-1 moves to SEL.
  - Bubbles (i_sym_valid=0) hold state and counter.
- SEL:
  - o_en_sel=1 until i_sel_done=1.
  - Moves to TB next cycle, loading o_tb_idx = FRAME_LEN-1.
- TB:
  - o_en_t=1.
  - o_tb_idx decrements each cycle and saturates at 0.
  - i_tb_done=1 moves to OUT and drops o_en_t.
  - If TB_TIMEOUT cycles elapse without i_tb_done: set o_err and go to IDLE.
- OUT:
  - o_out_valid=1 and held until i_out_ready=1 (handshake completes on valid&ready).
  - Next state is INIT if i_start=1 that same cycle, else IDLE.
- Minimum latency from start pulse to o_out_valid: 1 (INIT) + FRAME_LEN (ACS, no bubbles) + SEL cycles + TB cycles.
- Boundary conditions:
  - i_start outside IDLE/OUT is ignored (not queued).
  - i_abort in any non-IDLE state goes to IDLE next edge. Counters clear, strobes drop, o_err is unchanged. If i_abort=1 in OUT with i_out_ready=1, the handshake still completes and the state still goes to IDLE.
  - i_abort has priority over every other transition in the same cycle.
  - i_sel_done and i_tb_done outside their states are ignored.
  - i_sym_valid outside ACS: o_sym_ready=0, no o_en_acs.
  - rst mid-frame behaves identically to power-on reset.
  - Counter widths are IDX_W with no wrap: step never exceeds FRAME_LEN-1.
  - Timeout counter is ceil(log2(TB_TIMEOUT+1)) bits and clears on TB entry.

Decomposition:
- Shared package viterbi_pkg holds:
  - state enum encoding (IDLE..OUT, 3 bits);
  - constants FRAME_LEN=20, NUM_ST=256, ST_W=8 shared with the ACS, selector and traceback blocks.
- One natural sub-module, viterbi_step_cnt: a loadable up/down counter with terminal-count flag, instanced for step and traceback indices.
- FSM and timeout stay in the top.

Test Plan:
1. rst=1 for 2 cycles mid-ACS (step=7) -> all outputs 0 and state IDLE on the cycle after rst deasserts; next i_start runs a clean frame with o_step_idx restarting at 0.
2. i_start pulse, 20 back-to-back valid symbols, i_sel_done after 3 cycles, i_tb_done after 20 TB cycles, i_out_ready=1 ->
   - exactly 1 o_clr_metric pulse;
   - 20 o_en_acs pulses with o_step_idx 0..19;
   - o_tb_idx 19 down to 0 then held;
   - o_out_valid high 1 cycle; return to IDLE.
3. Random bubbles on i_sym_valid (30% low) -> still exactly 20 o_en_acs, indices contiguous, no o_en_acs when i_sym_valid=0.
4. i_out_ready held low 10 cycles -> o_out_valid stays high 10+ cycles; i_start during the wait ignored; i_start=1 with i_out_ready=1 -> INIT the next cycle (back-to-back frame).
5. i_tb_done never asserted -> after 64 TB cycles o_err=1 and IDLE; o_err persists until the next i_start.
6. i_abort at ACS step 5, and separately in SEL -> IDLE next edge, o_busy=0, o_en_acs/o_en_sel drop immediately, no o_out_valid.
